mdu_iter: RTL and testbench

- Iterative multiply/divide unit in the EX stage, next to the ALU.
- Produces the HI/LO values that feed the 32-bit 2:1 result-select mux ahead of EX/MEM; `hi_o` and `lo_o` drive the select-mux inputs for MFHI/MFLO.
- Multi-cycle, so it raises `busy` for the hazard logic to stall IF/ID/EX.

---
 rtl/cpu_defs.sv | 27 ++
 rtl/mdu_sign_fix.sv | 13 +
 rtl/mdu_iter.sv | 158 +++++++++++++++
 tb/tb_mdu_iter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: MDU opcodes, MDU state encoding and word width.
package cpu_defs;

  localparam int unsigned WORD_W = 32;

  localparam logic [2:0] MDU_OP_MULT  = 3'd0;
  localparam logic [2:0] MDU_OP_MULTU = 3'd1;
  localparam logic [2:0] MDU_OP_DIV   = 3'd2;
  localparam logic [2:0] MDU_OP_DIVU  = 3'd3;
  localparam logic [2:0] MDU_OP_MTHI  = 3'd4;
  localparam logic [2:0] MDU_OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // Per-operation control captured when an arithmetic op is accepted.
  typedef struct packed {
    logic is_div;
    logic neg_q;
    logic neg_r;
    logic dz;
  } mdu_ctl_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used as abs() on operands and as
// sign correction on products, quotients and remainders.
module mdu_sign_fix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val_c
);

  assign o_val_c = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: 32 shift-add / restoring shift-subtract
// iterations, then one sign-fix cycle that commits HI/LO and pulses done.
module mdu_iter
  import cpu_defs::*;
#(
  parameter int unsigned WIDTH = WORD_W,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  mdu_state_e r_state, w_state_nxt;
  logic w_load, w_iter, w_commit, w_mthi, w_mtlo;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_rem;
  logic [WIDTH-1:0]   r_mcand;
  logic [CNT_W-1:0]   r_cnt;
  mdu_ctl_t           r_ctl;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_busy, r_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= MDU_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_iter      = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      MDU_IDLE: begin
        if (start && !flush) begin
          case (op)
            MDU_OP_MULT, MDU_OP_MULTU, MDU_OP_DIV, MDU_OP_DIVU: begin
              w_load      = 1'b1;
              w_state_nxt = MDU_CALC;
            end
            MDU_OP_MTHI: w_mthi = 1'b1;
            MDU_OP_MTLO: w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      MDU_CALC: begin
        if (flush) begin
          w_state_nxt = MDU_IDLE;
        end else begin
          w_iter = 1'b1;
          if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = MDU_FIX;
        end
      end
      MDU_FIX: begin
        w_state_nxt = MDU_IDLE;
        w_commit    = !flush;
      end
      default: w_state_nxt = MDU_IDLE;
    endcase
  end

  // Operand preparation: magnitudes and result signs.
  logic             w_signed, w_is_div, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;

  assign w_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
  assign w_is_div = (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];

  mdu_sign_fix #(.W(WIDTH)) u_abs_a (.i_val(a), .i_neg(w_a_neg), .o_val_c(w_a_abs));
  mdu_sign_fix #(.W(WIDTH)) u_abs_b (.i_val(b), .i_neg(w_b_neg), .o_val_c(w_b_abs));

  // One multiply step: conditional add into the upper half, then shift right.
  logic [WIDTH:0] w_madd;
  assign w_madd = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};

  // One restoring divide step; r_rem never exceeds the divisor, so the
  // trial difference always fits back into WIDTH+1 bits.
  logic [WIDTH+1:0] w_dshift;
  logic             w_dlt;
  logic [WIDTH:0]   w_ddiff;
  assign w_dshift = {r_rem, r_acc[WIDTH-1]};
  assign w_dlt    = w_dshift < {2'b00, r_mcand};
  assign w_ddiff  = w_dshift[WIDTH:0] - {1'b0, r_mcand};

  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  mdu_sign_fix #(.W(2*WIDTH)) u_fix_prod (.i_val(r_acc), .i_neg(r_ctl.neg_q), .o_val_c(w_prod_fix));
  mdu_sign_fix #(.W(WIDTH)) u_fix_quo (.i_val(r_acc[WIDTH-1:0]), .i_neg(r_ctl.neg_q), .o_val_c(w_quo_fix));
  mdu_sign_fix #(.W(WIDTH)) u_fix_rem (.i_val(r_rem[WIDTH-1:0]), .i_neg(r_ctl.neg_r), .o_val_c(w_rem_fix));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= '0;
      r_rem   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_ctl   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != MDU_IDLE);
      r_done <= w_commit;
      if (w_load) begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_mcand <= w_is_div ? w_b_abs : w_a_abs;
        r_acc   <= {{WIDTH{1'b0}}, (w_is_div ? w_a_abs : w_b_abs)};
        r_ctl   <= '{is_div: w_is_div, neg_q: w_a_neg ^ w_b_neg,
                     neg_r: w_a_neg, dz: (b == '0)};
      end
      if (w_iter) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_ctl.is_div) begin
          r_rem              <= w_dlt ? w_dshift[WIDTH:0] : w_ddiff;
          r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], ~w_dlt};
        end else begin
          r_acc <= r_acc[0] ? {w_madd, r_acc[WIDTH-1:1]}
                            : {1'b0, r_acc[2*WIDTH-1:1]};
        end
      end
      if (w_mthi) r_hi <= a;
      if (w_mtlo) r_lo <= a;
      if (w_commit) begin
        if (r_ctl.is_div) begin
          r_hi <= w_rem_fix;
          r_lo <= r_ctl.dz ? '1 : w_quo_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, multi-cycle corner
// sequences, and random operations against an arithmetic reference model.
module tb_mdu_iter;

  logic        clk, rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi_o, lo_o;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_iter dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: HI/LO straight from integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint p;
    int     q, r;
    case (o)
      3'd0: begin p = longint'($signed(x)) * longint'($signed(y)); return p; end
      3'd1: return {32'b0, x} * {32'b0, y};
      3'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Issue one op and observe up to 40 edges; optional second start,
  // flush or reset presented at a given edge index (-1 = none).
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inj_at, input int fl_at, input int rs_at,
                        output logic [31:0] rhi, output logic [31:0] rlo,
                        output int busy_cnt, output int done_at, output int done_cnt);
    logic [63:0] pre;
    busy_cnt = 0;
    done_at  = -1;
    done_cnt = 0;
    pre      = '0;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (k == 0) pre = {hi_o, lo_o};
      if (k == 32 && rs_at < 0) chk("no_early_update", {hi_o, lo_o}, pre);
      if (done_at >= 0 && k >= done_at + 1) break;
      start = (k == inj_at - 1);
      flush = (k == fl_at - 1);
      rst   = (k == rs_at - 1);
      if (start) begin op = 3'd3; a = 32'd1000; b = 32'd7; end
      @(posedge clk); #1;
    end
    start = 1'b0; flush = 1'b0; rst = 1'b0;
    rhi = hi_o;
    rlo = lo_o;
  endtask

  task automatic do_arith(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] rhi, rlo;
    int bc, da, dc;
    run_op(o, x, y, -1, -1, -1, rhi, rlo, bc, da, dc);
    chk($sformatf("%s busy_cycles", tag), 64'(bc), 64'd33);
    chk($sformatf("%s done_edge", tag), 64'(da), 64'd33);
    chk($sformatf("%s done_pulses", tag), 64'(dc), 64'd1);
    chk($sformatf("%s hi", tag), 64'(rhi), 64'(ehi));
    chk($sformatf("%s lo", tag), 64'(rlo), 64'(elo));
  endtask

  initial begin
    logic [31:0] rhi, rlo, x, y;
    logic [63:0] exp, prev;
    logic [2:0]  o;
    int bc, da, dc, sel;

    vecs[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{3'd0, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{3'd3, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
    vecs[6] = '{3'd2, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[7] = '{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd7; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset hi", 64'(hi_o), 64'd0);
    chk("reset lo", 64'(lo_o), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    rst = 1'b0;

    foreach (vecs[i])
      do_arith($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // MTHI then MTLO on back-to-back edges.
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hAAAA_5555;
    @(posedge clk); #1;
    chk("mthi hi", 64'(hi_o), 64'hAAAA_5555);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    op = 3'd5; a = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mtlo lo", 64'(lo_o), 64'h0F0F_0F0F);
    chk("mtlo hi kept", 64'(hi_o), 64'hAAAA_5555);
    chk("mtlo busy", 64'(busy), 64'd0);
    chk("mtlo done", 64'(done), 64'd0);

    // Flush in IDLE cancels a simultaneous MTHI and a simultaneous MULTU.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(posedge clk); #1;
    chk("idle_flush mthi", 64'(hi_o), 64'hAAAA_5555);
    op = 3'd1; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("idle_flush mult busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    chk("idle_flush mult busy2", 64'(busy), 64'd0);

    // Start while busy is ignored.
    exp = model(3'd1, 32'h0001_2345, 32'h0001_0000);
    run_op(3'd1, 32'h0001_2345, 32'h0001_0000, 5, -1, -1, rhi, rlo, bc, da, dc);
    chk("ignore busy_cycles", 64'(bc), 64'd33);
    chk("ignore done_edge", 64'(da), 64'd33);
    chk("ignore hi", 64'(rhi), 64'(exp[63:32]));
    chk("ignore lo", 64'(rlo), 64'(exp[31:0]));

    // Flush mid-divide.
    prev = {hi_o, lo_o};
    run_op(3'd3, 32'd1000, 32'd3, -1, 10, -1, rhi, rlo, bc, da, dc);
    chk("flush busy_cycles", 64'(bc), 64'd10);
    chk("flush done_pulses", 64'(dc), 64'd0);
    chk("flush hilo kept", {rhi, rlo}, prev);
    do_arith("after_flush", 3'd3, 32'd1000, 32'd3, 32'd1, 32'd333);

    // Reset mid-divide.
    run_op(3'd3, 32'd1000, 32'd3, -1, -1, 10, rhi, rlo, bc, da, dc);
    chk("rst busy_cycles", 64'(bc), 64'd10);
    chk("rst done_pulses", 64'(dc), 64'd0);
    chk("rst hi", 64'(rhi), 64'd0);
    chk("rst lo", 64'(rlo), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);

    for (int n = 0; n < 20; n++) begin
      o   = 3'($urandom_range(0, 3));
      x   = $urandom;
      y   = $urandom;
      sel = int'($urandom_range(0, 7));
      if (sel == 0) y = 32'h0;
      if (sel == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (sel == 2) y = 32'($urandom_range(1, 15));
      if (sel == 3) x = 32'($urandom_range(0, 100));
      exp = model(o, x, y);
      do_arith($sformatf("rnd%0d op%0d a=%h b=%h", n, o, x, y), o, x, y, exp[63:32], exp[31:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
